// File: rtl/ps2_key_tracker_if.sv
// Decoded key-event stream between the PS/2 tracker and its consumer.
// Latency: none, this is wiring only.
// Backpressure: the consumer holds evt_ready low to stall; the head entry stays put.
// Ports: evt_valid/evt_data flow from the tracker (master) to the consumer (slave);
//        evt_ready flows back from the consumer.
interface ps2_key_tracker_if;
    logic       evt_valid;
    logic       evt_ready;
    logic [9:0] evt_data;   // {ext, brk, code[7:0]}

    modport master (output evt_valid, output evt_data, input evt_ready);
    modport slave  (input evt_valid, input evt_data, output evt_ready);
endinterface

// File: rtl/ps2_key_tracker.sv
// PS/2 keyboard front-end: sync/filter, 11-bit frame RX, E0/F0/E1 parsing, held-key levels, event FIFO.
// Latency: byte_done at N+1 after the stop-bit edge N, key_held at N+2, evt_valid at N+3 when the FIFO was empty.
// Backpressure: evt_ready low stalls the FIFO head; a push into a full FIFO is dropped with an evt_overflow pulse.
// Ports: clk/rst (async, active low), raw ps2_clk/ps2_data, key_held[NUM_KEYS] levels,
//        frame_err and evt_overflow one-cycle pulses, evt (ready/valid event stream, master side).
module ps2_key_tracker #(
    parameter int NUM_KEYS = 4,
    // Key i lives at KEY_CODES[8*i+:8] and KEY_EXT[i]: key0=W(1D), key1=S(1B), key2=Up(E0 75), key3=Down(E0 72).
    parameter logic [8*NUM_KEYS-1:0] KEY_CODES = {8'h72, 8'h75, 8'h1B, 8'h1D},
    parameter logic [NUM_KEYS-1:0]   KEY_EXT   = 4'b1100,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 65000,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ps2_clk,
    input  logic                ps2_data,
    output logic [NUM_KEYS-1:0] key_held,
    output logic                frame_err,
    output logic                evt_overflow,
    ps2_key_tracker_if.master   evt
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int AW = $clog2(FIFO_DEPTH);

    // ---------------- synchronisers and clock filter ----------------
    logic [1:0]    clk_sync_q, dat_sync_q;
    logic          filt_q, filt_prev_q;
    logic [FW-1:0] filt_cnt_q;
    logic          dat_s, fall;

    assign dat_s = dat_sync_q[1];
    assign fall  = filt_prev_q & ~filt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // Idle lines are high; resetting to 1 avoids a false falling edge after reset.
            clk_sync_q  <= 2'b11;
            dat_sync_q  <= 2'b11;
            filt_q      <= 1'b1;
            filt_prev_q <= 1'b1;
            filt_cnt_q  <= '0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk};
            dat_sync_q  <= {dat_sync_q[0], ps2_data};
            filt_prev_q <= filt_q;
            if (clk_sync_q[1] == filt_q) begin
                filt_cnt_q <= '0;
            end else if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
                filt_q     <= clk_sync_q[1];
                filt_cnt_q <= '0;
            end else begin
                filt_cnt_q <= filt_cnt_q + 1'b1;
            end
        end
    end

    // ---------------- frame receiver ----------------
    typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PAR, RX_STOP} rx_e;
    rx_e           rx_q, rx_d;
    logic [7:0]    shift_q;
    logic [2:0]    bit_cnt_q;
    logic          par_ok_q;
    logic [TW-1:0] tmo_q;
    logic          tmo_hit, rx_ok, rx_err;
    logic          byte_done_q, frame_err_q;

    // An edge landing on the expiry cycle wins over the timeout.
    assign tmo_hit = (rx_q != RX_IDLE) && !fall && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rx_q <= RX_IDLE;
        else      rx_q <= rx_d;
    end

    always_comb begin
        rx_d = rx_q;
        if (tmo_hit) begin
            rx_d = RX_IDLE;
        end else if (fall) begin
            case (rx_q)
                RX_IDLE: if (!dat_s) rx_d = RX_DATA;
                RX_DATA: if (bit_cnt_q == 3'd7) rx_d = RX_PAR;
                RX_PAR:  rx_d = RX_STOP;
                default: rx_d = RX_IDLE;
            endcase
        end
    end

    always_comb begin
        rx_ok  = 1'b0;
        rx_err = 1'b0;
        if (tmo_hit) begin
            rx_err = 1'b1;
        end else if (fall && rx_q == RX_STOP) begin
            rx_ok  = dat_s & par_ok_q;
            rx_err = ~(dat_s & par_ok_q);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            par_ok_q    <= 1'b0;
            tmo_q       <= '0;
            byte_done_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            tmo_q       <= (rx_q == RX_IDLE || fall) ? '0 : tmo_q + 1'b1;
            byte_done_q <= rx_ok;
            frame_err_q <= rx_err;
            if (fall && rx_q == RX_IDLE) bit_cnt_q <= '0;
            if (fall && rx_q == RX_DATA) begin
                shift_q   <= {dat_s, shift_q[7:1]};
                bit_cnt_q <= bit_cnt_q + 1'b1;
            end
            // Odd parity: data plus parity bit must carry an odd number of ones.
            if (fall && rx_q == RX_PAR) par_ok_q <= ^{shift_q, dat_s};
        end
    end

    // ---------------- prefix parser ----------------
    typedef enum logic [2:0] {P_BASE, P_EXT, P_BRK, P_EXT_BRK, P_SKIP} ps_e;
    ps_e        ps_q, ps_d;
    logic [2:0] skip_q, skip_d;
    logic       ev_vld, ev_ext, ev_brk;
    logic       is_ctrl;

    assign is_ctrl = (shift_q == 8'hAA) || (shift_q == 8'hFA) || (shift_q == 8'hEE) ||
                     (shift_q == 8'hFE) || (shift_q == 8'h00) || (shift_q == 8'hFF);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ps_q   <= P_BASE;
            skip_q <= '0;
        end else begin
            ps_q   <= ps_d;
            skip_q <= skip_d;
        end
    end

    always_comb begin
        ps_d   = ps_q;
        skip_d = skip_q;
        if (frame_err_q) begin
            ps_d = P_BASE;
        end else if (byte_done_q) begin
            case (ps_q)
                P_BASE: begin
                    if (shift_q == 8'hE0)      ps_d = P_EXT;
                    else if (shift_q == 8'hF0) ps_d = P_BRK;
                    else if (shift_q == 8'hE1) begin
                        // Pause: E1 plus seven more bytes that carry no key information.
                        ps_d   = P_SKIP;
                        skip_d = 3'd7;
                    end
                end
                P_EXT:   ps_d = (shift_q == 8'hF0) ? P_EXT_BRK : P_BASE;
                P_SKIP: begin
                    skip_d = skip_q - 1'b1;
                    if (skip_q == 3'd1) ps_d = P_BASE;
                end
                default: ps_d = P_BASE;
            endcase
        end
    end

    always_comb begin
        ev_vld = 1'b0;
        ev_ext = 1'b0;
        ev_brk = 1'b0;
        if (byte_done_q) begin
            case (ps_q)
                P_BASE: ev_vld = !is_ctrl && shift_q != 8'hE0 && shift_q != 8'hF0 && shift_q != 8'hE1;
                P_EXT: begin
                    ev_vld = shift_q != 8'hE0 && shift_q != 8'hF0 && shift_q != 8'hE1;
                    ev_ext = 1'b1;
                end
                P_BRK: begin
                    ev_vld = 1'b1;
                    ev_brk = 1'b1;
                end
                P_EXT_BRK: begin
                    ev_vld = 1'b1;
                    ev_brk = 1'b1;
                    ev_ext = 1'b1;
                end
                default: ev_vld = 1'b0;
            endcase
        end
    end

    // ---------------- held keys, typematic suppression, event staging ----------------
    logic [NUM_KEYS-1:0] key_held_q, key_held_d;
    logic [8:0]          sup_key_q;
    logic                sup_vld_q, dup;
    logic                ev_push_q;
    logic [9:0]          ev_dat_q;

    assign dup = sup_vld_q && (sup_key_q == {ev_ext, shift_q});

    always_comb begin
        key_held_d = key_held_q;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (ev_vld && {ev_ext, shift_q} == {KEY_EXT[i], KEY_CODES[8*i +: 8]})
                key_held_d[i] = ~ev_brk;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_held_q <= '0;
            sup_key_q  <= '0;
            sup_vld_q  <= 1'b0;
            ev_push_q  <= 1'b0;
            ev_dat_q   <= '0;
        end else begin
            key_held_q <= key_held_d;
            // Auto-repeat makes of the key last reported are not queued again until it is released.
            ev_push_q  <= ev_vld && (ev_brk || !dup);
            ev_dat_q   <= {ev_ext, ev_brk, shift_q};
            if (ev_vld && !ev_brk && !dup) begin
                sup_key_q <= {ev_ext, shift_q};
                sup_vld_q <= 1'b1;
            end else if (ev_vld && ev_brk && dup) begin
                sup_vld_q <= 1'b0;
            end
        end
    end

    // ---------------- event FIFO ----------------
    logic [9:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic          fifo_vld, full, pop, do_push, ovf_q;

    assign fifo_vld = (cnt_q != '0);
    assign full     = (cnt_q == (AW + 1)'(FIFO_DEPTH));
    assign pop      = fifo_vld && evt.evt_ready;
    assign do_push  = ev_push_q && (!full || pop);

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= ev_dat_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ev_push_q && full && !pop;
            if (do_push) wr_q <= wr_q + 1'b1;
            if (pop)     rd_q <= rd_q + 1'b1;
            case ({do_push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign key_held      = key_held_q;
    assign frame_err     = frame_err_q;
    assign evt_overflow  = ovf_q;
    assign evt.evt_valid = fifo_vld;
    assign evt.evt_data  = fifo_vld ? mem_q[rd_q] : 10'h000;
endmodule

// File: tb/tb_ps2_key_tracker.sv
// Randomised + directed bench for ps2_key_tracker against an event-level keyboard model.
module tb_ps2_key_tracker;
    localparam int TMO = 2000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [3:0] key_held;
    logic       frame_err, evt_overflow;

    ps2_key_tracker_if evt_if ();

    ps2_key_tracker #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk          (clk),
        .rst          (rst),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .key_held     (key_held),
        .frame_err    (frame_err),
        .evt_overflow (evt_overflow),
        .evt          (evt_if)
    );

    initial forever #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- behavioural model ----------------
    logic [8:0] trk [4] = '{9'h01D, 9'h01B, 9'h175, 9'h172};
    logic [3:0] model_held;
    logic [9:0] exp_q [$];
    logic [9:0] seen_q [$];
    logic [8:0] last_make;
    bit         last_vld, ext_p, brk_p;
    int         skip_n;
    int         err_exp = 0, ovf_exp = 0, err_seen = 0, ovf_seen = 0;
    bit         chk_en = 0, glitch_en = 0;
    int         rdy_mode = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        model_held = '0;
        exp_q.delete();
        last_vld = 0;
        ext_p = 0;
        brk_p = 0;
        skip_n = 0;
    endtask

    task automatic emit(input bit ext, input bit brk, input logic [7:0] code);
        logic [8:0] key;
        key = {ext, code};
        for (int i = 0; i < 4; i++) if (trk[i] == key) model_held[i] = !brk;
        if (!brk) begin
            if (last_vld && last_make == key) return;
            last_make = key;
            last_vld  = 1;
        end else if (last_vld && last_make == key) begin
            last_vld = 0;
        end
        if (exp_q.size() >= 4) ovf_exp++;
        else exp_q.push_back({ext, brk, code});
    endtask

    task automatic model_err();
        err_exp++;
        ext_p = 0;
        brk_p = 0;
        skip_n = 0;
    endtask

    task automatic model_byte(input logic [7:0] b, input bit bad);
        if (bad) begin
            model_err();
        end else if (skip_n > 0) begin
            skip_n--;
        end else if (brk_p) begin
            emit(ext_p, 1'b1, b);
            ext_p = 0;
            brk_p = 0;
        end else if (ext_p) begin
            if (b == 8'hF0) brk_p = 1;
            else if (b == 8'hE0 || b == 8'hE1) ext_p = 0;
            else begin
                emit(1'b1, 1'b0, b);
                ext_p = 0;
            end
        end else begin
            case (b)
                8'hE0: ext_p = 1;
                8'hF0: brk_p = 1;
                8'hE1: skip_n = 7;
                8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: ;
                default: emit(1'b0, 1'b0, b);
            endcase
        end
    endtask

    // ---------------- PS/2 line driver ----------------
    task automatic send_bit(input logic b);
        ps2_data = b;
        repeat (10) @(negedge clk);
        if (glitch_en && $urandom_range(0, 3) == 0) begin
            ps2_clk = 1'b0;
            repeat (3) @(negedge clk);
            ps2_clk = 1'b1;
            repeat (3) @(negedge clk);
        end
        ps2_clk = 1'b0;
        repeat (20) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad);
        logic par;
        par = (~^b) ^ bad;
        chk_en = 0;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(par);
        ps2_data = 1'b1;
        repeat (10) @(negedge clk);
        ps2_clk = 1'b0;
        model_byte(b, bad);
        repeat (20) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (40) @(negedge clk);
        chk_en = 1;
        repeat (10) @(negedge clk);
    endtask

    task automatic send_partial(input int nbits);
        chk_en = 0;
        send_bit(1'b0);
        for (int i = 0; i < nbits; i++) send_bit(1'($urandom_range(0, 1)));
        ps2_data = 1'b1;
    endtask

    function automatic logic [7:0] pick();
        int r;
        logic [7:0] v;
        r = $urandom_range(0, 19);
        if (r < 6) begin
            case ($urandom_range(0, 3))
                0: v = 8'h1D;
                1: v = 8'h1B;
                2: v = 8'h75;
                default: v = 8'h72;
            endcase
        end else if (r < 9)  v = 8'hE0;
        else if (r < 11)     v = 8'hF0;
        else if (r == 11)    v = 8'hE1;
        else if (r == 12)    v = 8'hAA;
        else begin
            case ($urandom_range(0, 3))
                0: v = 8'h16;
                1: v = 8'h1C;
                2: v = 8'h24;
                default: v = 8'h2B;
            endcase
        end
        return v;
    endfunction

    // ---------------- compare process ----------------
    bit err_prev = 0, ovf_prev = 0;
    always @(negedge clk) begin
        case (rdy_mode)
            0:       evt_if.evt_ready = 1'b0;
            1:       evt_if.evt_ready = 1'b1;
            default: evt_if.evt_ready = 1'($urandom_range(0, 1));
        endcase
        if (evt_if.evt_valid && evt_if.evt_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL evt_unexpected: got 0x%0h, expected no event", evt_if.evt_data);
            end else if (evt_if.evt_data !== exp_q[0]) begin
                errors++;
                $display("FAIL evt_data: got 0x%0h, expected 0x%0h", evt_if.evt_data, exp_q[0]);
                void'(exp_q.pop_front());
            end else begin
                void'(exp_q.pop_front());
            end
            seen_q.push_back(evt_if.evt_data);
        end
        if (frame_err === 1'b1) begin
            err_seen++;
            if (err_prev) begin
                checks++;
                errors++;
                $display("FAIL frame_err_width: got 2+ cycles, expected 1");
            end
        end
        err_prev = (frame_err === 1'b1);
        if (evt_overflow === 1'b1) begin
            ovf_seen++;
            if (ovf_prev) begin
                checks++;
                errors++;
                $display("FAIL overflow_width: got 2+ cycles, expected 1");
            end
        end
        ovf_prev = (evt_overflow === 1'b1);
        if (chk_en) begin
            checks++;
            if (key_held !== model_held) begin
                errors++;
                $display("FAIL key_held: got 0x%0h, expected 0x%0h", key_held, model_held);
            end
        end
    end

    initial begin
        #(10 * 150000);
        $display("FAIL watchdog: got no finish, expected finish within budget");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    int e0, o0;
    initial begin
        model_reset();
        evt_if.evt_ready = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_key_held", 32'(key_held), 0);
        chk("rst_evt_valid", 32'(evt_if.evt_valid), 0);
        chk("rst_evt_data", 32'(evt_if.evt_data), 0);
        chk("rst_frame_err", 32'(frame_err), 0);
        chk("rst_overflow", 32'(evt_overflow), 0);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        chk_en = 1;

        // 1: single make, key_held at N+2 and evt_valid one cycle later
        fork
            send_frame(8'h1D, 0);
            begin : t1_wait
                int t;
                t = 0;
                while (key_held[0] !== 1'b1 && t < 3000) begin
                    @(negedge clk);
                    t++;
                end
                chk("t1_key_rise_in_time", 32'(t < 3000), 1);
                chk("t1_valid_low_at_key_rise", 32'(evt_if.evt_valid), 0);
                @(negedge clk);
                chk("t1_valid_next_cycle", 32'(evt_if.evt_valid), 1);
                chk("t1_evt_data", 32'(evt_if.evt_data), 32'h01D);
            end
        join
        rdy_mode = 1;
        repeat (10) @(negedge clk);
        chk("t1_pop_count", 32'(seen_q.size()), 1);
        chk("t1_popped", 32'(seen_q[0]), 32'h01D);

        // 2: extended make/break
        seen_q.delete();
        send_frame(8'hE0, 0); send_frame(8'h75, 0);
        chk("t2_up_held", 32'(key_held[2]), 1);
        send_frame(8'hE0, 0); send_frame(8'hF0, 0); send_frame(8'h75, 0);
        chk("t2_up_released", 32'(key_held[2]), 0);
        chk("t2_count", 32'(seen_q.size()), 2);
        chk("t2_ev0", 32'(seen_q[0]), 32'h275);
        chk("t2_ev1", 32'(seen_q[1]), 32'h375);

        // 3: typematic repeats collapse to one make
        seen_q.delete();
        repeat (5) send_frame(8'h1D, 0);
        send_frame(8'hF0, 0); send_frame(8'h1D, 0);
        chk("t3_count", 32'(seen_q.size()), 2);
        chk("t3_ev0", 32'(seen_q[0]), 32'h01D);
        chk("t3_ev1", 32'(seen_q[1]), 32'h11D);
        chk("t3_w_released", 32'(key_held[0]), 0);

        // 4: parity error then recovery
        seen_q.delete();
        e0 = err_seen;
        send_frame(8'h1B, 1);
        chk("t4_frame_err_pulses", 32'(err_seen - e0), 1);
        chk("t4_no_event", 32'(seen_q.size()), 0);
        chk("t4_held_unchanged", 32'(key_held), 0);
        send_frame(8'h1B, 0);
        chk("t4_s_held", 32'(key_held[1]), 1);
        send_frame(8'hF0, 0); send_frame(8'h1B, 0);

        // 5: overflow with consumer stalled
        rdy_mode = 0;
        repeat (5) @(negedge clk);
        seen_q.delete();
        o0 = ovf_seen;
        send_frame(8'h1D, 0); send_frame(8'h1B, 0);
        send_frame(8'hE0, 0); send_frame(8'h75, 0);
        send_frame(8'hE0, 0); send_frame(8'h72, 0);
        send_frame(8'h16, 0);
        chk("t5_overflow_pulses", 32'(ovf_seen - o0), 1);
        chk("t5_all_held", 32'(key_held), 32'hF);
        chk("t5_valid_while_full", 32'(evt_if.evt_valid), 1);
        rdy_mode = 1;
        repeat (20) @(negedge clk);
        chk("t5_drained", 32'(seen_q.size()), 4);
        chk("t5_ev0", 32'(seen_q[0]), 32'h01D);
        chk("t5_ev3", 32'(seen_q[3]), 32'h272);
        send_frame(8'hF0, 0); send_frame(8'h1D, 0);
        send_frame(8'hF0, 0); send_frame(8'h1B, 0);
        send_frame(8'hE0, 0); send_frame(8'hF0, 0); send_frame(8'h75, 0);
        send_frame(8'hE0, 0); send_frame(8'hF0, 0); send_frame(8'h72, 0);
        send_frame(8'hF0, 0); send_frame(8'h16, 0);
        chk("t5_all_released", 32'(key_held), 0);

        // 6: timeout mid-frame, then an extended key decodes
        e0 = err_seen;
        send_partial(4);
        model_err();
        repeat (TMO + 500) @(negedge clk);
        chk("t6_timeout_err", 32'(err_seen - e0), 1);
        chk_en = 1;
        send_frame(8'hE0, 0); send_frame(8'h72, 0);
        chk("t6_down_held", 32'(key_held[3]), 1);
        send_frame(8'hE0, 0); send_frame(8'hF0, 0); send_frame(8'h72, 0);

        // reset in the middle of a frame while a key is held
        send_frame(8'h1D, 0);
        chk("rst_mid_pre_held", 32'(key_held[0]), 1);
        send_partial(2);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        chk("rst_mid_key_held", 32'(key_held), 0);
        chk("rst_mid_valid", 32'(evt_if.evt_valid), 0);
        chk("rst_mid_frame_err", 32'(frame_err), 0);
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        chk_en = 1;
        e0 = err_seen;
        repeat (TMO + 500) @(negedge clk);
        chk("rst_release_no_err", 32'(err_seen - e0), 0);
        chk("rst_release_no_valid", 32'(evt_if.evt_valid), 0);
        seen_q.delete();
        send_frame(8'h1D, 0);
        chk("rst_sup_cleared_count", 32'(seen_q.size()), 1);
        chk("rst_sup_cleared_ev", 32'(seen_q[0]), 32'h01D);

        // randomised traffic with clock glitches and a random consumer
        glitch_en = 1;
        rdy_mode = 2;
        for (int n = 0; n < 50; n++) send_frame(pick(), $urandom_range(0, 14) == 0);
        glitch_en = 0;
        rdy_mode = 1;
        repeat (50) @(negedge clk);
        chk("end_model_drained", 32'(exp_q.size()), 0);
        chk("end_frame_err_total", 32'(err_seen), 32'(err_exp));
        chk("end_overflow_total", 32'(ovf_seen), 32'(ovf_exp));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
